// File: rtl/booth_pp_accum.sv
// booth_pp_accum: sequential radix-4 Booth partial-product generator/accumulator (2W-bit signed A*B).
// Optional BOOTH_ACC_DUAL_EN: retire two Booth digits per RUN cycle (NPP must be even).
module booth_pp_accum #(
  parameter int W   = 32,
  parameter int NPP = W/2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     b,
  input  logic [NPP-1:0]   set0,
  input  logic [NPP-1:0]   inv,
  input  logic [NPP-1:0]   x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product
);

  localparam int CW = (NPP > 1) ? $clog2(NPP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [W-1:0]     b_r;
  logic [NPP-1:0]   set0_r, inv_r, x2_r;
  logic [CW-1:0]    cnt;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   step_sum;
  logic             last_step;

  // Signed partial product for one digit; set0 wins over inv and x2.
  function automatic logic [2*W-1:0] pp(input logic s0, input logic neg,
                                        input logic dbl, input logic [W-1:0] bv);
    logic [2*W-1:0] m;
    m = {{W{bv[W-1]}}, bv};
    if (dbl) m = m << 1;
    if (s0)       pp = '0;
    else if (neg) pp = -m;
    else          pp = m;
  endfunction

`ifdef BOOTH_ACC_DUAL_EN
  localparam logic [CW-1:0] STEP = CW'(2);
  logic [CW-1:0] cnt_hi;
  assign cnt_hi    = cnt | CW'(1);
  assign step_sum  = (pp(set0_r[cnt], inv_r[cnt], x2_r[cnt], b_r) << {cnt, 1'b0})
                   + (pp(set0_r[cnt_hi], inv_r[cnt_hi], x2_r[cnt_hi], b_r) << {cnt_hi, 1'b0});
  assign last_step = (cnt == CW'(NPP-2));
`else
  localparam logic [CW-1:0] STEP = CW'(1);
  assign step_sum  = pp(set0_r[cnt], inv_r[cnt], x2_r[cnt], b_r) << {cnt, 1'b0};
  assign last_step = (cnt == CW'(NPP-1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_step) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured only at accept so upstream may move on immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r    <= '0;
      set0_r <= '0;
      inv_r  <= '0;
      x2_r   <= '0;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            b_r    <= b;
            set0_r <= set0;
            inv_r  <= inv;
            x2_r   <= x2;
            cnt    <= '0;
            acc    <= '0;
          end
        end
        RUN: begin
          acc <= acc + step_sum;
          cnt <= cnt + STEP;
        end
        default: ;
      endcase
    end
  end

  assign product = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Self-checking bench for booth_pp_accum: directed corners, stall, mid-op reset and random ops
// against a plain signed-multiply reference; Booth digit controls are derived from A in the bench.
module tb_booth_pp_accum;

  localparam int W   = 32;
  localparam int NPP = W/2;
`ifdef BOOTH_ACC_DUAL_EN
  localparam int LAT = NPP/2 + 1;
`else
  localparam int LAT = NPP + 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     b;
  logic [NPP-1:0]   set0, inv, x2;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  booth_pp_accum #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .b(b),
    .set0(set0), .inv(inv), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );

  // Radix-4 Booth digit d_j = a[2j-1] + a[2j] - 2*a[2j+1], with a[-1] = 0.
  task automatic encode(input logic [W-1:0] a, output logic [NPP-1:0] s0,
                        output logic [NPP-1:0] ng, output logic [NPP-1:0] dx);
    logic [W:0] ax;
    ax = {a, 1'b0};
    for (int j = 0; j < NPP; j++) begin
      int d;
      d = int'(ax[2*j]) + int'(ax[2*j+1]) - 2*int'(ax[2*j+2]);
      s0[j] = (d == 0);
      ng[j] = (d < 0);
      dx[j] = (d == 2) || (d == -2);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] bv);
    logic signed [2*W-1:0] sa, sb;
    sa = $signed({{W{a[W-1]}}, a});
    sb = $signed({{W{bv[W-1]}}, bv});
    return sa * sb;
  endfunction

  // Present an operation for one edge, then scramble the inputs.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] bv);
    logic [NPP-1:0] s0, ng, dx;
    @(negedge clk);
    encode(a, s0, ng, dx);
    set0 = s0; inv = ng; x2 = dx; b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    b    = $urandom;
    set0 = NPP'($urandom);
    inv  = NPP'($urandom);
    x2   = NPP'($urandom);
  endtask

  // Negedges from accept until out_valid; 0 means the bound expired.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0)
        $display("[TB] FAIL reset_idle cycle %0d: in_ready=%b out_valid=%b product=%h, required 1/0/0",
                 i, in_ready, out_valid, product);
      else passed++;
    end
  endtask

  task automatic test_directed;
    logic [W-1:0]   av [4];
    logic [W-1:0]   bv [4];
    logic [2*W-1:0] ev [4];
    int lat;
    av[0] = 32'd3;          bv[0] = 32'd5;          ev[0] = 64'd15;
    av[1] = -32'sd7;        bv[1] = 32'd6;          ev[1] = -64'sd42;
    av[2] = 32'h8000_0000;  bv[2] = 32'h8000_0000;  ev[2] = 64'h4000_0000_0000_0000;
    av[3] = 32'h7FFF_FFFF;  bv[3] = 32'hFFFF_FFFF;  ev[3] = 64'hFFFF_FFFF_8000_0001;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_op(av[i], bv[i]);
      wait_valid(lat);
      total++;
      if (lat !== LAT) $display("[TB] FAIL latency op%0d: got %0d required %0d", i, lat, LAT);
      else passed++;
      total++;
      if (product !== ev[i]) $display("[TB] FAIL product op%0d: got %h required %h", i, product, ev[i]);
      else passed++;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("[TB] FAIL valid_pulse op%0d: out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
      else passed++;
    end
  endtask

  task automatic test_stall;
    logic [W-1:0]   a1, b1;
    logic [NPP-1:0] s0, ng, dx;
    logic [2*W-1:0] exp;
    int lat;
    a1 = 32'd123456; b1 = -32'sd789;
    exp = ref_mul(a1, b1);
    out_ready = 1'b0;
    start_op(a1, b1);
    wait_valid(lat);
    total++;
    if (lat == 0) $display("[TB] FAIL stall_timeout: out_valid never rose");
    else passed++;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp)
        $display("[TB] FAIL stall_hold cycle %0d: out_valid=%b in_ready=%b product=%h, required 1/0/%h",
                 i, out_valid, in_ready, product, exp);
      else passed++;
      if (i == 4) begin
        encode(32'd99, s0, ng, dx);
        set0 = s0; inv = ng; x2 = dx; b = 32'd77;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL stall_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("[TB] FAIL busy_ignored: in_ready=%b required 1", in_ready);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    out_ready = 1'b1;
    start_op($urandom, $urandom);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0)
      $display("[TB] FAIL mid_reset: in_ready=%b out_valid=%b product=%h, required 1/0/0",
               in_ready, out_valid, product);
    else passed++;
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("[TB] FAIL mid_reset_discard: out_valid rose=%b required 0", seen);
    else passed++;
  endtask

  task automatic test_random;
    logic [W-1:0]   a1, b1;
    logic [2*W-1:0] exp;
    int lat, bad_hold, bad_prod;
    bad_hold = 0; bad_prod = 0;
    for (int n = 0; n < 1000; n++) begin
      a1 = $urandom; b1 = $urandom;
      case ($urandom_range(0, 7))
        0: a1 = 32'h8000_0000;
        1: b1 = 32'h8000_0000;
        2: a1 = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = ref_mul(a1, b1);
      out_ready = 1'b0;
      start_op(a1, b1);
      wait_valid(lat);
      if (lat == 0) begin
        total++;
        $display("[TB] FAIL random_timeout op%0d", n);
        break;
      end
      repeat ($urandom_range(0, 3)) begin
        if (out_valid !== 1'b1 || product !== exp) bad_hold++;
        @(negedge clk);
      end
      total++;
      if (product !== exp) begin
        bad_prod++;
        $display("[TB] FAIL random_product op%0d: A=%h B=%h got %h required %h", n, a1, b1, product, exp);
      end else passed++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = $urandom_range(0, 1);
    end
    total++;
    if (bad_hold != 0) $display("[TB] FAIL random_hold: %0d unstable stall cycles, required 0", bad_hold);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    b = '0; set0 = '0; inv = '0; x2 = '0;
    test_reset;
    test_directed;
    test_stall;
    test_reset_mid_run;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
